kuz_dec_sequencer: RTL and testbench

KUZ_DEC_SEQUENCER -- requirements
Module: kuz_dec_sequencer

---
 rtl/kuz_pkg.sv | 29 ++
 rtl/kuz_rkey_store.sv | 49 ++++
 rtl/kuz_dec_sequencer.sv | 172 +++++++++++++++++
 tb/tb_kuz_dec_sequencer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kuz_pkg.sv
// ===== kuz_pkg : shared widths, sequencer states and round-key types (rev 1.0) =====
`default_nettype none

package kuz_pkg;

  localparam int BLK_W  = 128;
  localparam int KEY_W  = 256;
  localparam int ROUNDS = 10;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KS_RUN = 3'd1,
    READY  = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    OUT    = 3'd5
  } seq_state_e;

  // Element j holds round key K(j+1); matches the Key_calculation bus layout.
  typedef logic [ROUNDS-1:0][BLK_W-1:0] rkey_arr_t;

  function automatic logic state_is_busy(input seq_state_e s);
    return !((s == IDLE) || (s == READY));
  endfunction

endpackage

`default_nettype wire

// File: rtl/kuz_rkey_store.sv
// ===== kuz_rkey_store : 10x128 round-key register file, parallel load, read by index 1..10 (rev 1.0) =====
`default_nettype none

module kuz_rkey_store
  import kuz_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [ROUNDS*BLK_W-1:0] keys_in,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [BLK_W-1:0]        rd_key
);

  rkey_arr_t keys;

  for (genvar i = 0; i < ROUNDS; i++) begin : g_entry
    logic [BLK_W-1:0] key_q;
    logic [BLK_W-1:0] key_d;

    always_comb begin
      key_d = key_q;
      if (load) begin
        key_d = keys_in[BLK_W*(i+1)-1 -: BLK_W];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        key_q <= '0;
      end else begin
        key_q <= key_d;
      end
    end

    assign keys[i] = key_q;
  end

  // Index 0 and anything above ROUNDS read as zero.
  always_comb begin
    rd_key = '0;
    if ((rd_idx >= IDX_W'(1)) && (rd_idx <= IDX_W'(ROUNDS))) begin
      rd_key = keys[rd_idx - IDX_W'(1)];
    end
  end

endmodule

`default_nettype wire

// File: rtl/kuz_dec_sequencer.sv
// ===== kuz_dec_sequencer : Kuznyechik decryption round sequencer with key-schedule control (rev 1.0) =====
`default_nettype none

module kuz_dec_sequencer
  import kuz_pkg::*;
#(
  parameter int KS_TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_load,
  input  logic [KEY_W-1:0]        key,
  output logic                    ks_enable,
  output logic [KEY_W-1:0]        ks_key,
  input  logic                    ks_finish,
  input  logic [ROUNDS*BLK_W-1:0] ks_keys,
  output logic                    key_ready,
  output logic                    ks_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLK_W-1:0]        in_block,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLK_W-1:0]        out_block,
  output logic                    rnd_start,
  output logic [BLK_W-1:0]        rnd_data,
  input  logic                    rnd_done,
  input  logic [BLK_W-1:0]        rnd_result,
  output logic                    busy
);

  localparam int CNT_W = $clog2(KS_TIMEOUT + 1);

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               key_ready_q, key_ready_d;
  logic               ks_err_q, ks_err_d;

  logic               store_load;
  logic [IDX_W-1:0]   rd_idx;
  logic [BLK_W-1:0]   rd_key;

  kuz_rkey_store u_rkey_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (store_load),
    .keys_in (ks_keys),
    .rd_idx  (rd_idx),
    .rd_key  (rd_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      blk_q       <= '0;
      key_q       <= '0;
      key_ready_q <= 1'b0;
      ks_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      key_ready_q <= key_ready_d;
      ks_err_q    <= ks_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    key_d       = key_q;
    key_ready_d = key_ready_q;
    ks_err_d    = ks_err_q;
    store_load  = 1'b0;
    rd_idx      = idx_q;
    ks_enable   = 1'b0;
    in_ready    = 1'b0;
    rnd_start   = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_load) begin
          key_d       = key;
          ks_err_d    = 1'b0;
          key_ready_d = 1'b0;
          cnt_d       = '0;
          state_d     = KS_RUN;
        end
      end

      KS_RUN: begin
        ks_enable = 1'b1;
        if (ks_finish) begin
          store_load  = 1'b1;
          key_ready_d = 1'b1;
          state_d     = READY;
        end else if (cnt_q == CNT_W'(KS_TIMEOUT - 1)) begin
          ks_err_d    = 1'b1;
          key_ready_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      READY: begin
        // Whitening with K10 happens on acceptance, so the read port points at it here.
        rd_idx   = IDX_W'(ROUNDS);
        in_ready = !key_load;
        if (key_load) begin
          key_d       = key;
          ks_err_d    = 1'b0;
          key_ready_d = 1'b0;
          cnt_d       = '0;
          state_d     = KS_RUN;
        end else if (in_valid) begin
          blk_d   = in_block ^ rd_key;
          idx_d   = IDX_W'(ROUNDS - 1);
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        rnd_start = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        if (rnd_done) begin
          blk_d = rnd_result ^ rd_key;
          if (idx_q == IDX_W'(1)) begin
            state_d = OUT;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ISSUE;
          end
        end
      end

      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = READY;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ks_key    = key_q;
  assign key_ready = key_ready_q;
  assign ks_err    = ks_err_q;
  assign out_block = blk_q;
  assign rnd_data  = blk_q;
  assign busy      = state_is_busy(state_q);

endmodule

`default_nettype wire

// File: tb/tb_kuz_dec_sequencer.sv
// ===== tb_kuz_dec_sequencer : randomized scoreboard bench with key-schedule and round-unit models (rev 1.0) =====
`default_nettype none

module tb_kuz_dec_sequencer;

  localparam int TMO = 40;

  logic            clk;
  logic            rst_n;
  logic            key_load;
  logic [255:0]    key;
  logic            ks_enable;
  logic [255:0]    ks_key;
  logic            ks_finish;
  logic [1279:0]   ks_keys;
  logic            key_ready;
  logic            ks_err;
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    in_block;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    out_block;
  logic            rnd_start;
  logic [127:0]    rnd_data;
  logic            rnd_done;
  logic [127:0]    rnd_result;
  logic            busy;

  kuz_dec_sequencer #(.KS_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key        (key),
    .ks_enable  (ks_enable),
    .ks_key     (ks_key),
    .ks_finish  (ks_finish),
    .ks_keys    (ks_keys),
    .key_ready  (key_ready),
    .ks_err     (ks_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .rnd_start  (rnd_start),
    .rnd_data   (rnd_data),
    .rnd_done   (rnd_done),
    .rnd_result (rnd_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [127:0] mk [1:10];
  logic [127:0] gk [1:10];
  int  ks_lat;
  bit  ks_never;
  bit  rnd_ident;
  int  rnd_fix;
  int  oready_mode;

  typedef struct {
    logic [127:0] exp;
    int           acc;
    int           lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  function automatic logic [127:0] mixf(input logic [127:0] x);
    return {x[118:0], x[127:119]} + 128'h9e3779b97f4a7c15f39cc0605cedc834;
  endfunction

  // Decryption as stated: whiten with K10, then nine rounds of f() followed by K9..K1.
  function automatic logic [127:0] ref_dec(input logic [127:0] c, input bit ident);
    logic [127:0] p;
    p = c ^ mk[10];
    for (int i = 9; i >= 1; i--) begin
      p = (ident ? p : mixf(p)) ^ mk[i];
    end
    return p;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Key_calculation model: finishes after ks_lat enabled cycles, junk on the bus otherwise.
  initial begin
    int ks_cnt;
    ks_cnt    = 0;
    ks_finish = 1'b0;
    ks_keys   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ks_enable) begin
        ks_cnt++;
        if (!ks_never && ks_cnt == ks_lat) begin
          ks_finish = 1'b1;
          for (int i = 1; i <= 10; i++) begin
            ks_keys[128*i-1 -: 128] = gk[i];
            mk[i] = gk[i];
          end
        end else begin
          ks_finish = 1'b0;
          for (int i = 1; i <= 10; i++) ks_keys[128*i-1 -: 128] = rnd128();
        end
      end else begin
        ks_cnt    = 0;
        ks_finish = 1'b0;
      end
    end
  end

  // Round unit model with fixed or random latency.
  initial begin
    logic [127:0] rp_d;
    int           rp_l;
    rnd_done   = 1'b0;
    rnd_result = '0;
    forever begin
      @(negedge clk);
      if (rnd_start) begin
        rp_d = rnd_data;
        rp_l = (rnd_fix > 0) ? rnd_fix : $urandom_range(1, 4);
        repeat (rp_l) @(posedge clk);
        #1;
        rnd_done   = 1'b1;
        rnd_result = rnd_ident ? rp_d : mixf(rp_d);
        @(posedge clk);
        #1;
        rnd_done   = 1'b0;
        rnd_result = rnd128();
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (oready_mode)
        1:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pop, hold stability, latency and round-pulse count.
  initial begin
    bit           prev_ov;
    logic [127:0] prev_ob;
    int           rcnt;
    exp_t         e;
    prev_ov = 1'b0;
    prev_ob = '0;
    rcnt    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        rcnt    = 0;
      end else begin
        if (rnd_start) rcnt++;
        if (prev_ov) begin
          chk("out_hold_valid", 256'(out_valid), 256'(1));
          chk("out_hold_block", 256'(out_block), 256'(prev_ob));
        end
        if (out_valid && !prev_ov) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 256'(1), 256'(0));
          end else if (exp_q[0].lat >= 0) begin
            chk("out_latency", 256'(cyc - exp_q[0].acc), 256'(exp_q[0].lat));
          end
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_block", 256'(out_block), 256'(e.exp));
          chk("rnd_pulses", 256'(rcnt), 256'(9));
          rcnt = 0;
        end
        prev_ov = out_valid && !out_ready;
        prev_ob = out_block;
      end
    end
  end

  task automatic load_keys(input logic [255:0] k, input int lat, input bit never, output int en);
    ks_lat   = lat;
    ks_never = never;
    @(posedge clk);
    #1;
    key      = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    en = 0;
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge clk);
      if (ks_enable) en++;
      else if (en > 0 || i > 2) break;
    end
  endtask

  task automatic send(input logic [127:0] c, input int lat);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_block = c;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.exp = ref_dec(c, rnd_ident);
        e.acc = cyc;
        e.lat = lat;
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 256'(0), 256'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 256'(exp_q.size()), 256'(0));
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ks_key"}, ks_key, 256'(0));
    chk({tag, "_out_block"}, 256'(out_block), 256'(0));
    chk({tag, "_rnd_data"}, 256'(rnd_data), 256'(0));
    chk({tag, "_ctrl"}, 256'({ks_enable, key_ready, ks_err, in_ready, out_valid, rnd_start, busy}), 256'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int           en;
    logic [255:0] k35;
    logic [255:0] klast;
    bit           seen;
    int           saw_ov;

    key_load    = 1'b0;
    key         = '0;
    in_valid    = 1'b0;
    in_block    = '0;
    ks_lat      = 20;
    ks_never    = 1'b0;
    rnd_ident   = 1'b1;
    rnd_fix     = 1;
    oready_mode = 0;
    for (int i = 1; i <= 10; i++) begin
      mk[i] = '0;
      gk[i] = '0;
    end

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Known master key: K1/K2 are its halves; verified through an identity round unit.
    k35 = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    gk[1] = k35[255:128];
    gk[2] = k35[127:0];
    for (int i = 3; i <= 10; i++) gk[i] = rnd128();
    load_keys(k35, 20, 1'b0, en);
    chk("ks_enable_cycles", 256'(en), 256'(20));
    chk("key_ready_set", 256'(key_ready), 256'(1));
    chk("ks_key_held", ks_key, k35);
    chk("ks_err_clear", 256'(ks_err), 256'(0));
    chk("ready_not_busy", 256'(busy), 256'(0));
    send(rnd128(), 19);
    drain();

    // K_i = i in byte 0, zero input: result is 1^2^..^10 in byte 0.
    for (int i = 1; i <= 10; i++) gk[i] = 128'(i);
    load_keys(rnd256(), 5, 1'b0, en);
    chk("ks_enable_cycles_small", 256'(en), 256'(5));
    send(128'h0, 19);
    drain();

    // Randomized keys, round latency and output backpressure.
    rnd_ident   = 1'b0;
    rnd_fix     = 0;
    oready_mode = 1;
    for (int r = 0; r < 3; r++) begin
      int lat;
      lat = $urandom_range(1, 30);
      for (int i = 1; i <= 10; i++) gk[i] = rnd128();
      klast = rnd256();
      load_keys(klast, lat, 1'b0, en);
      chk("ks_enable_cycles_rand", 256'(en), 256'(lat));
      chk("ks_key_rand", ks_key, klast);
      for (int b = 0; b < 5; b++) begin
        send(rnd128(), -1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain();
    end

    // Output held back for five cycles with key_load pulses mid-block and in OUT.
    oready_mode = 2;
    rnd_fix     = 2;
    send(rnd128(), 9 * 3 + 1);
    key      = rnd256();
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_out_valid_seen", 256'(seen), 256'(1));
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      key_load = (j == 1);
      key      = rnd256();
      @(negedge clk);
      chk("bp_no_ks", 256'(ks_enable), 256'(0));
      chk("bp_key_ready", 256'(key_ready), 256'(1));
    end
    @(posedge clk);
    #1;
    key_load    = 1'b0;
    oready_mode = 0;
    drain();
    chk("bp_ks_key_kept", ks_key, klast);
    send(rnd128(), 9 * 3 + 1);
    drain();

    // Key schedule that never finishes.
    load_keys(rnd256(), 0, 1'b1, en);
    chk("tmo_enable_cycles", 256'(en), 256'(TMO));
    chk("tmo_ks_err", 256'(ks_err), 256'(1));
    chk("tmo_key_ready", 256'(key_ready), 256'(0));
    chk("tmo_in_ready", 256'(in_ready), 256'(0));
    chk("tmo_busy", 256'(busy), 256'(0));

    // Recover, then reset during WAIT with a round result still pending.
    for (int i = 1; i <= 10; i++) gk[i] = rnd128();
    load_keys(rnd256(), 10, 1'b0, en);
    chk("recover_key_ready", 256'(key_ready), 256'(1));
    chk("recover_ks_err", 256'(ks_err), 256'(0));
    rnd_fix = 6;
    send(rnd128(), -1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rnd_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_rnd_start_seen", 256'(seen), 256'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    saw_ov = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid || rnd_start) saw_ov++;
    end
    chk("post_rst_quiet", 256'(saw_ov), 256'(0));
    chk("post_rst_busy", 256'(busy), 256'(0));
    chk("post_rst_key_ready", 256'(key_ready), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
